// File: rtl/cam_pkg.sv
// cam_pkg: shared state encoding and default geometry for the camera frame sequencer
package cam_pkg;
   localparam int CNT_W_DEF   = 12;
   localparam int H_WORDS_DEF = 320;
   localparam int V_LINES_DEF = 240;
   typedef enum logic [1:0] {IDLE, ARM, CAPTURE, DONE} state_t;
endpackage

// File: rtl/cam_sync_edge.sv
// cam_sync_edge: registers a raw camera strobe and flags level changes, polarity-normalised
module cam_sync_edge
   import cam_pkg::*;
#(
   parameter bit POL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic act,
   output logic chg
);
   logic q, q_d;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         q   <= 1'b0;
         q_d <= 1'b0;
      end else begin
         q   <= d;
         q_d <= q;
      end
   assign act = q == POL;
   assign chg = q != q_d;
endmodule

// File: rtl/cam_frame_seq.sv
// cam_frame_seq: gates whole camera frames into the FIFO and reports per-frame geometry/drop status
module cam_frame_seq
   import cam_pkg::*;
#(
   parameter int H_WORDS   = H_WORDS_DEF,
   parameter int V_LINES   = V_LINES_DEF,
   parameter bit VSYNC_POL = 1'b1,
   parameter int CNT_W     = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             vsync,
   input  logic             href,
   input  logic             pix_valid,
   input  logic             capture_req,
   input  logic             cont_en,
   input  logic             abort,
   input  logic             fifo_full,
   output logic             fifo_wr_en,
   output logic             frame_active,
   output logic             frame_done,
   output logic             frame_bad,
   output logic             err_sticky,
   output logic [CNT_W-1:0] line_cnt,
   output logic [CNT_W-1:0] drop_cnt
);
   state_t state;
   logic [CNT_W-1:0] word_cnt, w_nxt, l_nxt;
   logic v_act, v_chg, h_act, h_chg;
   logic vs_start, vs_end, h_fall, drop, bad, bad_nxt;

   cam_sync_edge #(.POL(VSYNC_POL)) u_vs (.clk(clk), .reset(reset), .d(vsync), .act(v_act), .chg(v_chg));
   cam_sync_edge #(.POL(1'b1))      u_hs (.clk(clk), .reset(reset), .d(href),  .act(h_act), .chg(h_chg));

   assign vs_start     = v_chg & ~v_act;
   assign vs_end       = v_chg & v_act;
   assign h_fall       = h_chg & ~h_act;
   assign frame_active = state == CAPTURE;
   assign fifo_wr_en   = pix_valid & frame_active & ~fifo_full;
   assign drop         = pix_valid & fifo_full;
   assign w_nxt        = word_cnt + CNT_W'(pix_valid);
   // line total must include a line closing in the same cycle as vsync
   assign l_nxt        = line_cnt + CNT_W'(h_fall && line_cnt != '1);
   assign bad_nxt      = bad | drop | (h_fall && w_nxt != CNT_W'(H_WORDS))
                       | (vs_end && l_nxt != CNT_W'(V_LINES));

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state      <= IDLE;
         word_cnt   <= '0;
         line_cnt   <= '0;
         drop_cnt   <= '0;
         bad        <= 1'b0;
         frame_done <= 1'b0;
         frame_bad  <= 1'b0;
         err_sticky <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         frame_bad  <= 1'b0;
         if (capture_req) err_sticky <= 1'b0;
         if (abort) state <= IDLE;
         else case (state)
            IDLE: if (capture_req) state <= ARM;
            ARM: if (vs_start) begin
               state    <= CAPTURE;
               word_cnt <= '0;
               line_cnt <= '0;
               drop_cnt <= '0;
               bad      <= 1'b0;
            end
            CAPTURE: begin
               word_cnt <= h_fall ? '0 : w_nxt;
               line_cnt <= l_nxt;
               drop_cnt <= drop_cnt + CNT_W'(drop && drop_cnt != '1);
               bad      <= bad_nxt;
               if (vs_end) begin
                  state      <= DONE;
                  frame_done <= 1'b1;
                  frame_bad  <= bad_nxt;
                  if (bad_nxt) err_sticky <= 1'b1;
               end
            end
            default: state <= cont_en ? ARM : IDLE;
         endcase
      end
endmodule

// File: doc/cam_frame_seq.md
Name: cam_frame_seq

Overview:
Frame capture sequencer between the 8-to-16 pixel packer and the camera FIFO write port, running in the pixel clock domain.
- Arms on request and aligns to a full frame using vsync edges.
- Gates FIFO wr_en so only whole frames are written.
- Checks line and pixel geometry, counts drops on FIFO full, and reports a per-frame done/bad status to the USB/readout side.

Parameters:
H_WORDS, 320, 16-bit words expected per line (href window)
V_LINES, 240, lines expected per frame
VSYNC_POL, 1, vsync active level (1 = active-high pulse marks frame boundary)
CNT_W, 12, width of line/word/drop counters

Ports:
clk  in  1  pixel clock (pclk), all logic on rising edge
reset  in  1  asynchronous, active-high
vsync  in  1  camera vsync, raw
href  in  1  camera href, raw
pix_valid  in  1  16-bit word ready strobe from packer, 1-cycle
capture_req  in  1  1-cycle pulse: capture next full frame
cont_en  in  1  level: re-arm automatically after each frame
abort  in  1  1-cycle pulse: return to IDLE, stop writes
fifo_full  in  1  FIFO full flag
fifo_wr_en  out  1  gated FIFO write enable
frame_active  out  1  high while in CAPTURE
frame_done  out  1  1-cycle pulse at end of captured frame
frame_bad  out  1  valid with frame_done: geometry error or drops in frame
err_sticky  out  1  set on any bad frame; cleared only by reset or capture_req
line_cnt  out  CNT_W  lines completed in current/last frame
drop_cnt  out  CNT_W  words dropped on full in current/last frame, saturating

Behaviour:
- Reset values: all outputs 0; state IDLE; edge registers 0.
- vsync and href are registered once (v_q, h_q).
- Edge definitions:
  - vs_start: v_q leaves the active level.
  - vs_end: v_q enters the active level.
  - h_fall: h_q falls.
- States:
  - IDLE -> ARM on capture_req.
  - ARM -> CAPTURE on vs_start. The ARM entry cycle never counts as a start, so a frame already in progress is skipped.
  - CAPTURE -> DONE on vs_end.
  - DONE (1 cycle) -> ARM if cont_en, else IDLE.
  - Any state -> IDLE on abort. Abort wins over every simultaneous event.
  - An aborted frame produces no frame_done.
- On entry to CAPTURE, the following are cleared: line_cnt, the word counter, drop_cnt, and the per-frame bad flag.
- fifo_wr_en = pix_valid & (state==CAPTURE) & ~fifo_full. This is combinational, with zero latency relative to pix_valid.
- pix_valid & fifo_full in CAPTURE: the word is dropped, drop_cnt increments (saturates at all-ones), and bad is set.
- pix_valid outside CAPTURE is ignored silently.
- Word counter increments on each pix_valid in CAPTURE, whether written or dropped.
- On h_fall in CAPTURE:
  - If word counter != H_WORDS, bad is set.
  - line_cnt increments, saturating.
  - Word counter is cleared.
- On vs_end in CAPTURE: if line_cnt != V_LINES (after any same-cycle h_fall increment), bad is set.
- DONE: frame_done=1 for one cycle and frame_bad = bad. If bad, err_sticky is set.
- Counters hold their values in IDLE/ARM/DONE until the next CAPTURE entry.
- capture_req:
  - Clears err_sticky in all states.
  - In ARM/CAPTURE/DONE it is otherwise ignored; it does not restart the frame.
- cont_en deasserted mid-frame: the current frame completes, then the block goes to IDLE.
- Async reset mid-frame: fifo_wr_en drops immediately.

Decomposition:
- Shared package cam_pkg holds:
  - the state encoding (IDLE, ARM, CAPTURE, DONE);
  - default geometry constants (320 words, 240 lines);
  - CNT_W.
- One natural sub-module, cam_sync_edge: a register plus edge-detect for vsync/href with polarity parameter, instantiated twice.

Test Plan:
1. Reset, capture_req mid-frame, then two clean frames of 240 lines x 320 words: the first partial frame has fifo_wr_en=0. Frame 2 gives 76800 writes, frame_done with frame_bad=0, line_cnt=240, block returns to IDLE.
2. cont_en=1, three clean frames: three frame_done pulses, each with 76800 writes. Zero writes occur during vsync gaps.
3. fifo_full held for 10 pix_valid strobes on line 5: drop_cnt=10, 76790 writes, frame_bad=1, err_sticky=1. A later capture_req clears err_sticky.
4. One line of 319 words (also 241 lines in a separate run): frame_bad=1 at frame_done, drop_cnt=0.
5. abort on line 100: fifo_wr_en=0 from the next cycle, state IDLE, no frame_done. Then capture_req leads to a clean frame.
6. Async reset asserted mid-line, coincident with pix_valid: fifo_wr_en=0 in the same cycle and all outputs 0. Simultaneous h_fall and vs_end on the last line gives line_cnt=240 and frame_bad=0.
